penalty_game_fsm: RTL and testbench

- Parametrised successor to the two-state menu/game controller in the HDMI top level.
- Scans all USB keycode slots, not just slot 0. Generates single-cycle key-press events from held keycodes.
- Runs a full penalty-shootout round sequence: menu, aim, shoot, result, game over. Counts goals and saves and times phases in frames.
- Sits between the MicroBlaze keycode GPIOs and color_mapper. Consumes save_detect and the ball-arrival flag; drives game state to the renderer and HEX drivers.

---
 rtl/game_pkg.sv | 16 +
 rtl/key_edge_detect.sv | 36 +++
 rtl/penalty_game_fsm.sv | 138 +++++++++++++
 tb/tb_penalty_game_fsm.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default keycodes for the penalty shootout controller.
package game_pkg;

  typedef enum logic [2:0] {
    MENU   = 3'd0,
    AIM    = 3'd1,
    SHOOT  = 3'd2,
    RESULT = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam logic [7:0] KEY_START_DEF = 8'h28;
  localparam logic [7:0] KEY_EXIT_DEF  = 8'h29;
  localparam logic [7:0] KEY_SHOOT_DEF = 8'h2C;

endpackage

// File: rtl/key_edge_detect.sv
// Turns one keycode held in any slot into a single-cycle press event.
module key_edge_detect
  import game_pkg::*;
#(
  parameter int         NUM_SLOTS = 8,
  parameter logic [7:0] KEY       = KEY_START_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_SLOTS-1:0] keycodes,
  output logic                   held,
  output logic                   press
);

  logic [NUM_SLOTS-1:0] hit;
  logic                 prev;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign hit[i] = (keycodes[8*i +: 8] == KEY);
  end

  // History tracks the live key during reset, so a key held across release
  // looks already-seen and cannot fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      held <= |hit;
      prev <= |hit;
    end else begin
      held <= |hit;
      prev <= held;
    end
  end

  assign press = held & ~prev;

endmodule

// File: rtl/penalty_game_fsm.sv
// Penalty shootout round sequencer: menu, aim, shoot, result, game over.
// Optional SUDDEN_DEATH_EN: a tie at the end of regulation keeps playing.
module penalty_game_fsm
  import game_pkg::*;
#(
  parameter int         NUM_SLOTS     = 8,
  parameter int         ROUNDS        = 5,
  parameter int         RESULT_FRAMES = 120,
  parameter int         AIM_TIMEOUT   = 600,
  parameter logic [7:0] KEY_START     = KEY_START_DEF,
  parameter logic [7:0] KEY_EXIT      = KEY_EXIT_DEF,
  parameter logic [7:0] KEY_SHOOT     = KEY_SHOOT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [8*NUM_SLOTS-1:0]        keycodes,
  input  logic                          frame_tick,
  input  logic                          shot_done,
  input  logic                          save_detect,
  output logic [2:0]                    state,
  output logic [$clog2(ROUNDS+1)-1:0]   round_idx,
  output logic [$clog2(ROUNDS+1)-1:0]   goals,
  output logic [$clog2(ROUNDS+1)-1:0]   saves,
  output logic                          shoot_pulse,
  output logic                          result_goal,
  output logic                          game_over
);

  localparam int CW   = $clog2(ROUNDS+1);
  localparam int TMAX = (AIM_TIMEOUT > RESULT_FRAMES) ? AIM_TIMEOUT : RESULT_FRAMES;
  localparam int TW   = $clog2(TMAX+1);
  localparam logic [TW-1:0] AIM_LAST = TW'(AIM_TIMEOUT-1);
  localparam logic [TW-1:0] RES_LAST = TW'(RESULT_FRAMES-1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0] unused_held;
  logic       start_press, exit_press, shot_press;

  key_edge_detect #(.NUM_SLOTS(NUM_SLOTS), .KEY(KEY_START)) u_start (
    .clk(clk), .reset(reset), .keycodes(keycodes), .held(unused_held[0]), .press(start_press));
  key_edge_detect #(.NUM_SLOTS(NUM_SLOTS), .KEY(KEY_EXIT)) u_exit (
    .clk(clk), .reset(reset), .keycodes(keycodes), .held(unused_held[1]), .press(exit_press));
  key_edge_detect #(.NUM_SLOTS(NUM_SLOTS), .KEY(KEY_SHOOT)) u_shoot (
    .clk(clk), .reset(reset), .keycodes(keycodes), .held(unused_held[2]), .press(shot_press));

  state_t          st, st_nx;
  logic [TW-1:0]   tmr, tmr_nx;
  logic [CW-1:0]   rnd, rnd_nx, gl, gl_nx, sv, sv_nx, rnd_inc;
  logic            sticky, sticky_nx, rg, rg_nx, play_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= MENU;
      tmr    <= '0;
      rnd    <= '0;
      gl     <= '0;
      sv     <= '0;
      sticky <= 1'b0;
      rg     <= 1'b0;
    end else begin
      st     <= st_nx;
      tmr    <= tmr_nx;
      rnd    <= rnd_nx;
      gl     <= gl_nx;
      sv     <= sv_nx;
      sticky <= sticky_nx;
      rg     <= rg_nx;
    end
  end

  assign rnd_inc = sat_inc(rnd);
`ifdef SUDDEN_DEATH_EN
  assign play_done = (rnd_inc >= CW'(ROUNDS)) && (gl != sv);
`else
  assign play_done = (rnd_inc == CW'(ROUNDS));
`endif

  always_comb begin
    st_nx       = st;
    tmr_nx      = (frame_tick && !(&tmr)) ? tmr + 1'b1 : tmr;
    rnd_nx      = rnd;
    gl_nx       = gl;
    sv_nx       = sv;
    sticky_nx   = sticky;
    rg_nx       = rg;
    shoot_pulse = 1'b0;
    if (exit_press && st != MENU) begin
      st_nx = MENU;
    end else begin
      case (st)
        MENU: if (start_press) begin
          st_nx     = AIM;
          rnd_nx    = '0;
          gl_nx     = '0;
          sv_nx     = '0;
          sticky_nx = 1'b0;
        end
        AIM: if (shot_press || (frame_tick && tmr == AIM_LAST)) begin
          st_nx       = SHOOT;
          shoot_pulse = 1'b1;
        end
        SHOOT: begin
          if (save_detect) sticky_nx = 1'b1;
          if (shot_done) begin
            st_nx = RESULT;
            if (save_detect || sticky) begin
              rg_nx = 1'b0;
              sv_nx = sat_inc(sv);
            end else begin
              rg_nx = 1'b1;
              gl_nx = sat_inc(gl);
            end
          end
        end
        RESULT: if (frame_tick && tmr == RES_LAST) begin
          rnd_nx    = rnd_inc;
          sticky_nx = 1'b0;
          st_nx     = play_done ? OVER : AIM;
        end
        OVER: if (start_press) st_nx = MENU;
        default: st_nx = MENU;
      endcase
    end
    // Every phase timer restarts from zero on state entry.
    if (st_nx != st) tmr_nx = '0;
  end

  assign state       = st;
  assign round_idx   = rnd;
  assign goals       = gl;
  assign saves       = sv;
  assign result_goal = rg;
  assign game_over   = (st == OVER);

endmodule

// File: tb/tb_penalty_game_fsm.sv
// Bench for penalty_game_fsm: vector table, scripted scenarios, random run vs model.
module tb_penalty_game_fsm;

  localparam int NS = 8;
  localparam int KW = 8*NS;
`ifdef SUDDEN_DEATH_EN
  localparam int RN = 2;
`else
  localparam int RN = 5;
`endif
  localparam int RF   = 4;
  localparam int AT   = 600;
  localparam int CW   = $clog2(RN+1);
  localparam int CMAX = (1 << CW) - 1;

  localparam int S_MENU = 0, S_AIM = 1, S_SHOOT = 2, S_RESULT = 3, S_OVER = 4;
  localparam logic [KW-1:0] K3E = 64'h0000_0000_2800_0000;
  localparam logic [KW-1:0] SP0 = 64'h0000_0000_0000_002C;
  localparam logic [KW-1:0] ESC = 64'h0000_2900_0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [KW-1:0] keycodes;
  logic          frame_tick, shot_done, save_detect;
  logic [2:0]    state;
  logic [CW-1:0] round_idx, goals, saves;
  logic          shoot_pulse, result_goal, game_over;

  penalty_game_fsm #(.NUM_SLOTS(NS), .ROUNDS(RN), .RESULT_FRAMES(RF), .AIM_TIMEOUT(AT)) dut (
    .clk(clk), .reset(reset), .keycodes(keycodes), .frame_tick(frame_tick),
    .shot_done(shot_done), .save_detect(save_detect), .state(state),
    .round_idx(round_idx), .goals(goals), .saves(saves), .shoot_pulse(shoot_pulse),
    .result_goal(result_goal), .game_over(game_over));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, pulses = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: unbounded phase frame count, clamped score counters.
  int m_st, m_ticks, m_rnd, m_gl, m_sv, m_rg;
  bit m_saved;
  bit m_held[3], m_prev[3];
  logic [7:0] keys [3] = '{8'h28, 8'h29, 8'h2C};

  function automatic bit has_key(input logic [KW-1:0] kc, input logic [7:0] k);
    for (int i = 0; i < NS; i++) if (kc[8*i +: 8] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pressed(input int k);
    return m_held[k] && !m_prev[k];
  endfunction

  function automatic int clamp(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic bit m_pulse(input bit ft);
    return m_st == S_AIM && !pressed(1) && (pressed(2) || (ft && m_ticks == AT-1));
  endfunction

  task automatic model_step(input logic [KW-1:0] kc, input bit ft, input bit sd, input bit svd);
    int nst;
    bit fin;
    nst = m_st;
    if (pressed(1) && m_st != S_MENU) nst = S_MENU;
    else if (m_st == S_MENU && pressed(0)) begin
      nst = S_AIM; m_rnd = 0; m_gl = 0; m_sv = 0; m_saved = 0;
    end else if (m_st == S_AIM && (pressed(2) || (ft && m_ticks == AT-1))) nst = S_SHOOT;
    else if (m_st == S_SHOOT) begin
      if (sd) begin
        nst = S_RESULT;
        if (svd || m_saved) begin m_rg = 0; m_sv = clamp(m_sv + 1); end
        else begin m_rg = 1; m_gl = clamp(m_gl + 1); end
      end
      if (svd) m_saved = 1;
    end else if (m_st == S_RESULT && ft && m_ticks == RF-1) begin
      m_rnd = clamp(m_rnd + 1);
      m_saved = 0;
`ifdef SUDDEN_DEATH_EN
      fin = (m_rnd >= RN) && (m_gl != m_sv);
`else
      fin = (m_rnd == RN);
`endif
      nst = fin ? S_OVER : S_AIM;
    end else if (m_st == S_OVER && pressed(0)) nst = S_MENU;
    if (nst != m_st) m_ticks = 0;
    else if (ft) m_ticks++;
    m_st = nst;
    for (int k = 0; k < 3; k++) begin
      m_prev[k] = m_held[k];
      m_held[k] = has_key(kc, keys[k]);
    end
  endtask

  task automatic do_reset(input logic [KW-1:0] kc);
    reset = 1'b1; keycodes = kc; frame_tick = 0; shot_done = 0; save_detect = 0;
    repeat (2) @(posedge clk);
    m_st = S_MENU; m_ticks = 0; m_rnd = 0; m_gl = 0; m_sv = 0; m_rg = 0; m_saved = 0;
    for (int k = 0; k < 3; k++) begin
      m_held[k] = has_key(kc, keys[k]);
      m_prev[k] = m_held[k];
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle: drive at negedge, check against model, clock, advance model.
  task automatic cyc(input logic [KW-1:0] kc, input bit ft, input bit sd, input bit svd);
    keycodes = kc; frame_tick = ft; shot_done = sd; save_detect = svd;
    #1;
    chk("state", int'(state), m_st);
    chk("round_idx", int'(round_idx), m_rnd);
    chk("goals", int'(goals), m_gl);
    chk("saves", int'(saves), m_sv);
    chk("result_goal", int'(result_goal), m_rg);
    chk("game_over", int'(game_over), int'(m_st == S_OVER));
    chk("shoot_pulse", int'(shoot_pulse), int'(m_pulse(ft)));
    if (shoot_pulse) pulses++;
    @(posedge clk);
    model_step(kc, ft, sd, svd);
    @(negedge clk);
  endtask

  task automatic play_round(input bit save_mid, input bit save_coinc);
    cyc(SP0, 0, 0, 0);
    cyc(SP0, 0, 0, 0);
    cyc('0, 0, 0, 0);
    if (save_mid) begin
      cyc('0, 0, 0, 1);
      repeat (50) cyc('0, 0, 0, 0);
    end
    cyc('0, 0, 1, save_coinc);
    repeat (RF) cyc('0, 1, 0, 0);
    cyc('0, 0, 0, 0);
  endtask

  typedef struct {
    logic [KW-1:0] kc;
    bit ft, sd, sv;
    int st, rnd, gl, sa, rg, pl;
  } vec_t;

  vec_t tbl [24];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; keycodes = '0; frame_tick = 0; shot_done = 0; save_detect = 0;
    tbl[0]  = '{'0,  0,0,0, S_MENU,  0,0,0,0,0};
    tbl[1]  = '{K3E, 0,0,0, S_MENU,  0,0,0,0,0};
    tbl[2]  = '{K3E, 0,0,0, S_MENU,  0,0,0,0,0};
    tbl[3]  = '{K3E, 0,0,0, S_AIM,   0,0,0,0,0};
    tbl[4]  = '{SP0, 0,0,0, S_AIM,   0,0,0,0,0};
    tbl[5]  = '{SP0, 0,0,0, S_AIM,   0,0,0,0,1};
    tbl[6]  = '{'0,  0,0,0, S_SHOOT, 0,0,0,0,0};
    tbl[7]  = '{'0,  0,1,0, S_SHOOT, 0,0,0,0,0};
    tbl[8]  = '{'0,  0,0,0, S_RESULT,0,1,0,1,0};
    tbl[9]  = '{'0,  1,0,0, S_RESULT,0,1,0,1,0};
    tbl[10] = '{'0,  1,0,0, S_RESULT,0,1,0,1,0};
    tbl[11] = '{'0,  1,0,0, S_RESULT,0,1,0,1,0};
    tbl[12] = '{'0,  1,0,0, S_RESULT,0,1,0,1,0};
    tbl[13] = '{'0,  0,0,0, S_AIM,   1,1,0,1,0};
    tbl[14] = '{SP0, 0,0,0, S_AIM,   1,1,0,1,0};
    tbl[15] = '{SP0, 0,0,0, S_AIM,   1,1,0,1,1};
    tbl[16] = '{'0,  0,0,0, S_SHOOT, 1,1,0,1,0};
    tbl[17] = '{'0,  0,0,1, S_SHOOT, 1,1,0,1,0};
    tbl[18] = '{'0,  0,0,0, S_SHOOT, 1,1,0,1,0};
    tbl[19] = '{'0,  0,1,0, S_SHOOT, 1,1,0,1,0};
    tbl[20] = '{'0,  0,0,0, S_RESULT,1,1,1,0,0};
    tbl[21] = '{ESC, 0,0,0, S_RESULT,1,1,1,0,0};
    tbl[22] = '{ESC, 0,0,0, S_RESULT,1,1,1,0,0};
    tbl[23] = '{'0,  0,0,0, S_MENU,  1,1,1,0,0};

    @(negedge clk);
    do_reset('0);
    foreach (tbl[i]) begin
      keycodes = tbl[i].kc; frame_tick = tbl[i].ft; shot_done = tbl[i].sd; save_detect = tbl[i].sv;
      #1;
      chk($sformatf("tbl%0d.state", i), int'(state), tbl[i].st);
      chk($sformatf("tbl%0d.round", i), int'(round_idx), tbl[i].rnd);
      chk($sformatf("tbl%0d.goals", i), int'(goals), tbl[i].gl);
      chk($sformatf("tbl%0d.saves", i), int'(saves), tbl[i].sa);
      chk($sformatf("tbl%0d.result_goal", i), int'(result_goal), tbl[i].rg);
      chk($sformatf("tbl%0d.pulse", i), int'(shoot_pulse), tbl[i].pl);
      chk($sformatf("tbl%0d.game_over", i), int'(game_over), int'(tbl[i].st == S_OVER));
      @(posedge clk);
      model_step(tbl[i].kc, tbl[i].ft, tbl[i].sd, tbl[i].sv);
      @(negedge clk);
    end

    // Enter held through reset release must not start a game.
    do_reset(64'h28);
    repeat (5) cyc(64'h28, 0, 0, 0);
    chk("held_thru_reset", int'(state), S_MENU);

    // Enter in slot 3 held for 100 cycles: exactly one transition.
    do_reset('0);
    repeat (100) cyc(K3E, 0, 0, 0);
    chk("hold_enter_state", int'(state), S_AIM);

    // Aim timeout: auto shot on the 600th frame tick.
    begin
      int at_k;
      at_k = -1;
      pulses = 0;
      for (int k = 1; k <= AT; k++) begin
        int p0;
        p0 = pulses;
        cyc('0, 1, 0, 0);
        if (pulses != p0) at_k = k;
      end
      chk("timeout_pulses", pulses, 1);
      chk("timeout_tick", at_k, AT);
      chk("timeout_state", int'(state), S_SHOOT);
    end
    cyc('0, 0, 1, 1);
    chk("coinc_save", int'(saves), 1);
    chk("coinc_goals", int'(goals), 0);
    repeat (RF + 1) cyc('0, 1, 0, 0);

    // Full game.
    do_reset('0);
    cyc(K3E, 0, 0, 0); cyc(K3E, 0, 0, 0); cyc('0, 0, 0, 0);
`ifdef SUDDEN_DEATH_EN
    play_round(0, 0);
    play_round(1, 0);
    chk("sd_tie_state", int'(state), S_AIM);
    chk("sd_tie_round", int'(round_idx), 2);
    play_round(0, 0);
    chk("sd_over_state", int'(state), S_OVER);
    chk("sd_goals", int'(goals), 2);
    chk("sd_saves", int'(saves), 1);
`else
    play_round(0, 0);
    play_round(1, 0);
    play_round(0, 0);
    play_round(0, 1);
    play_round(0, 0);
    chk("game_state", int'(state), S_OVER);
    chk("game_over_flag", int'(game_over), 1);
    chk("game_round", int'(round_idx), 5);
    chk("game_goals", int'(goals), 3);
    chk("game_saves", int'(saves), 2);
`endif
    cyc(K3E, 0, 0, 0); cyc(K3E, 0, 0, 0); cyc('0, 0, 0, 0);
    chk("over_to_menu", int'(state), S_MENU);

    // Esc in the middle of a shot.
    do_reset('0);
    cyc(K3E, 0, 0, 0); cyc(K3E, 0, 0, 0);
    cyc(SP0, 0, 0, 0); cyc(SP0, 0, 0, 0); cyc('0, 0, 0, 0);
    chk("pre_esc_state", int'(state), S_SHOOT);
    cyc(ESC, 0, 0, 0); cyc(ESC, 0, 0, 0);
    chk("esc_state", int'(state), S_MENU);

    // Random run against the model.
    begin
      logic [KW-1:0] kc;
      kc = '0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 799) == 0) do_reset(kc);
        if ($urandom_range(0, 3) == 0) begin
          kc = '0;
          for (int s = 0; s < NS; s++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r < 3) kc[8*s +: 8] = keys[r];
            else if (r == 3) kc[8*s +: 8] = 8'h04;
          end
        end
        cyc(kc, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
